// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with show-ahead or registered read, arbitrary depth,
// programmable almost-full/almost-empty thresholds, flush and sticky error flags.
module sync_fifo_flex #(
  parameter int DW        = 8,
  parameter int DEPTH     = 16,
  parameter int SHOWAHEAD = 1,
  parameter int AFULL_TH  = DEPTH - 1,
  parameter int AEMPTY_TH = 1,
  localparam int AW       = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          wr,
  input  logic [DW-1:0] din,
  input  logic          rd,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          almost_empty,
  output logic          full,
  output logic          almost_full,
  output logic [AW:0]   usedw,
  output logic          ovf,
  output logic          udf,
  input  logic          err_clr
);

  localparam logic [AW:0]   DEPTH_U = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AF_U    = (AW+1)'(AFULL_TH);
  localparam logic [AW:0]   AE_U    = (AW+1)'(AEMPTY_TH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr, wptr_nxt, rptr_nxt;
  logic [AW:0]   usedw_nxt;
  logic          wr_int, rd_int;

  // Pointers wrap explicitly so non-power-of-two depths never index past the array.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + AW'(1);
  endfunction

  assign wr_int = wr & ~full & ~clr;
  assign rd_int = rd & ~empty & ~clr;

  always_comb begin
    wptr_nxt  = wptr;
    rptr_nxt  = rptr;
    usedw_nxt = usedw;
    if (clr) begin
      wptr_nxt  = '0;
      rptr_nxt  = '0;
      usedw_nxt = '0;
    end else begin
      if (wr_int) wptr_nxt = ptr_inc(wptr);
      if (rd_int) rptr_nxt = ptr_inc(rptr);
      if (wr_int && !rd_int)      usedw_nxt = usedw + (AW+1)'(1);
      else if (rd_int && !wr_int) usedw_nxt = usedw - (AW+1)'(1);
    end
  end

  // Control state: pointers, occupancy and flags all registered from the next occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr         <= '0;
      rptr         <= '0;
      usedw        <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      ovf          <= 1'b0;
      udf          <= 1'b0;
    end else begin
      wptr         <= wptr_nxt;
      rptr         <= rptr_nxt;
      usedw        <= usedw_nxt;
      empty        <= (usedw_nxt == '0);
      almost_empty <= (usedw_nxt <= AE_U);
      full         <= (usedw_nxt == DEPTH_U);
      almost_full  <= (usedw_nxt >= AF_U);
      if (wr && full && !clr) ovf <= 1'b1;
      else if (err_clr)       ovf <= 1'b0;
      if (rd && empty && !clr) udf <= 1'b1;
      else if (err_clr)        udf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_int) mem[wptr] <= din;
  end

  generate
    if (SHOWAHEAD != 0) begin : g_showahead
      // The incoming word becomes the head when nothing else remains after this edge.
      logic head_from_din;
      assign head_from_din = wr_int & (usedw == {{AW{1'b0}}, rd_int});

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
          dout <= '0;
        else if (usedw_nxt != '0)
          dout <= head_from_din ? din : mem[rptr_nxt];
      end
    end else begin : g_registered
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
          dout <= '0;
        else if (rd_int)
          dout <= mem[rptr];
      end
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Randomized and directed bench for sync_fifo_flex, both read modes driven in lockstep
// and compared against a queue-based reference model.
module tb_sync_fifo_flex;

  localparam int DW    = 8;
  localparam int DEPTH = 6;
  localparam int AFT   = 4;
  localparam int AET   = 1;

  logic clk = 1'b0;
  logic rstn, clr, wr, rd, err_clr;
  logic [DW-1:0] din;

  logic [DW-1:0] sa_dout, rg_dout;
  logic sa_empty, sa_ae, sa_full, sa_af, sa_ovf, sa_udf;
  logic rg_empty, rg_ae, rg_full, rg_af, rg_ovf, rg_udf;
  logic [3:0] sa_usedw, rg_usedw;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] q[$];
  bit            m_ovf, m_udf;
  logic [DW-1:0] m_rdout;

  always #5 clk = ~clk;

  sync_fifo_flex #(.DW(DW), .DEPTH(DEPTH), .SHOWAHEAD(1), .AFULL_TH(AFT), .AEMPTY_TH(AET)) u_sa (
    .clk(clk), .rstn(rstn), .clr(clr), .wr(wr), .din(din), .rd(rd),
    .dout(sa_dout), .empty(sa_empty), .almost_empty(sa_ae), .full(sa_full),
    .almost_full(sa_af), .usedw(sa_usedw), .ovf(sa_ovf), .udf(sa_udf), .err_clr(err_clr)
  );

  sync_fifo_flex #(.DW(DW), .DEPTH(DEPTH), .SHOWAHEAD(0), .AFULL_TH(AFT), .AEMPTY_TH(AET)) u_rg (
    .clk(clk), .rstn(rstn), .clr(clr), .wr(wr), .din(din), .rd(rd),
    .dout(rg_dout), .empty(rg_empty), .almost_empty(rg_ae), .full(rg_full),
    .almost_full(rg_af), .usedw(rg_usedw), .ovf(rg_ovf), .udf(rg_udf), .err_clr(err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    m_rdout = '0;
  endtask

  // Called just after a rising edge; the inputs still hold the values sampled at that edge.
  task automatic model_edge();
    int n;
    bit f, e, wi, ri;
    n  = q.size();
    f  = (n == DEPTH);
    e  = (n == 0);
    wi = wr && !f && !clr;
    ri = rd && !e && !clr;
    if (wr && f && !clr) m_ovf = 1'b1;
    else if (err_clr)    m_ovf = 1'b0;
    if (rd && e && !clr) m_udf = 1'b1;
    else if (err_clr)    m_udf = 1'b0;
    if (clr) q.delete();
    else begin
      if (ri) m_rdout = q.pop_front();
      if (wi) q.push_back(din);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ".sa.usedw"}, sa_usedw, n);
    chk({tag, ".rg.usedw"}, rg_usedw, n);
    chk({tag, ".sa.empty"}, sa_empty, n == 0);
    chk({tag, ".rg.empty"}, rg_empty, n == 0);
    chk({tag, ".sa.full"},  sa_full,  n == DEPTH);
    chk({tag, ".rg.full"},  rg_full,  n == DEPTH);
    chk({tag, ".sa.ae"},    sa_ae,    n <= AET);
    chk({tag, ".rg.ae"},    rg_ae,    n <= AET);
    chk({tag, ".sa.af"},    sa_af,    n >= AFT);
    chk({tag, ".rg.af"},    rg_af,    n >= AFT);
    chk({tag, ".sa.ovf"},   sa_ovf,   m_ovf);
    chk({tag, ".rg.ovf"},   rg_ovf,   m_ovf);
    chk({tag, ".sa.udf"},   sa_udf,   m_udf);
    chk({tag, ".rg.udf"},   rg_udf,   m_udf);
    chk({tag, ".rg.dout"},  rg_dout,  m_rdout);
    if (n > 0) chk({tag, ".sa.dout"}, sa_dout, q[0]);
  endtask

  task automatic step(input string tag, input bit w, input bit r, input logic [DW-1:0] d,
                      input bit c = 1'b0, input bit ec = 1'b0);
    wr = w; rd = r; din = d; clr = c; err_clr = ec;
    @(posedge clk);
    model_edge();
    #1;
    wr = 1'b0; rd = 1'b0; clr = 1'b0; err_clr = 1'b0;
    check_all(tag);
  endtask

  initial begin
    rstn = 1'b0; clr = 1'b0; wr = 1'b0; rd = 1'b0; err_clr = 1'b0; din = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset.sa.dout", sa_dout, 0);
    @(negedge clk) rstn = 1'b1;

    // Fill and drain
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 1'b0, 8'h10 + 8'(i));
    chk("fill.full", sa_full, 1);
    chk("fill.usedw", rg_usedw, 6);
    step("over", 1'b1, 1'b0, 8'h99);
    chk("over.ovf", rg_ovf, 1);
    chk("over.usedw", sa_usedw, 6);
    for (int i = 0; i < DEPTH; i++) begin
      if (i > 0) chk("drain.sa.seq", sa_dout, 8'h10 + 8'(i));
      step("drain", 1'b0, 1'b1, 8'h00);
      chk("drain.rg.seq", rg_dout, 8'h10 + 8'(i));
    end
    chk("drain.empty", sa_empty, 1);
    step("under", 1'b0, 1'b1, 8'h00);
    chk("under.udf", rg_udf, 1);
    step("errclr", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Wrap-around at usedw=3
    for (int i = 0; i < 3; i++) step("wrap.pre", 1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 20; i++) begin
      step("wrap", 1'b1, 1'b1, 8'($urandom));
      chk("wrap.usedw", sa_usedw, 3);
    end

    // Show-ahead simultaneous read/write at usedw=1
    step("sa.flush", 1'b0, 1'b0, 8'h00, 1'b1);
    step("sa.a1", 1'b1, 1'b0, 8'hA1);
    chk("sa.a1.dout", sa_dout, 8'hA1);
    step("sa.b2", 1'b1, 1'b1, 8'hB2);
    chk("sa.b2.dout", sa_dout, 8'hB2);
    chk("sa.b2.empty", sa_empty, 0);
    chk("sa.b2.usedw", sa_usedw, 1);

    // Flush with ovf set at usedw=4
    step("fl.clr0", 1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < DEPTH; i++) step("fl.fill", 1'b1, 1'b0, 8'h40 + 8'(i));
    step("fl.ovf", 1'b1, 1'b0, 8'hEE);
    step("fl.rd", 1'b0, 1'b1, 8'h00);
    step("fl.rd", 1'b0, 1'b1, 8'h00);
    chk("fl.usedw4", rg_usedw, 4);
    step("fl.clr", 1'b1, 1'b1, 8'h77, 1'b1);
    chk("fl.clr.usedw", sa_usedw, 0);
    chk("fl.clr.ovf", sa_ovf, 1);
    step("fl.ec", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("fl.ec.ovf", rg_ovf, 0);
    for (int i = 0; i < DEPTH; i++) step("fl.fill2", 1'b1, 1'b0, 8'h50 + 8'(i));
    step("fl.ecovf", 1'b1, 1'b0, 8'h66, 1'b0, 1'b1);
    chk("fl.ecovf.ovf", sa_ovf, 1);
    step("fl.clr2", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step("rnd", 1'($urandom), 1'($urandom), 8'($urandom),
           ($urandom_range(0, 24) == 0), ($urandom_range(0, 15) == 0));

    // Reset mid-operation at usedw=3
    step("rm.clr", 1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) step("rm.fill", 1'b1, 1'b0, 8'h30 + 8'(i));
    step("rm.ovfless", 1'b0, 1'b1, 8'h00);
    step("rm.refill", 1'b1, 1'b0, 8'h33);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    model_reset();
    check_all("rm.async");
    chk("rm.async.sa.dout", sa_dout, 0);
    @(posedge clk);
    #1;
    check_all("rm.hold");
    @(negedge clk) rstn = 1'b1;
    step("rm.wr", 1'b1, 1'b0, 8'h5A);
    chk("rm.wr.sa.dout", sa_dout, 8'h5A);
    step("rm.rd", 1'b0, 1'b1, 8'h00);
    chk("rm.rd.rg.dout", rg_dout, 8'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
